// File: rtl/lcd_char_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : lcd_char_responder_if
// Brief    : CPU-to-LCD byte handshake bundle (character byte, strobe, ready).
// Revision : 1.0
// ============================================================================
interface lcd_char_responder_if;
  logic [7:0] iData;
  logic       iData_Ready;
  logic       oReadyForData;

  modport master (output iData, output iData_Ready, input oReadyForData);
  modport slave  (input iData, input iData_Ready, output oReadyForData);
endinterface
`default_nettype wire

// File: rtl/lcd_char_responder.sv
`default_nettype none
// ============================================================================
// Module   : lcd_char_responder
// Brief    : HD44780 4-bit init plus one-character-per-handshake LCD writer.
//            Optional line wrap (0xC0 / 0x80 insertion) under LCD_LINE_WRAP_EN.
// Revision : 1.0
// ============================================================================
module lcd_char_responder #(
  parameter int T_PWRUP = 750000,
  parameter int T_INIT1 = 205000,
  parameter int T_INIT2 = 5000,
  parameter int T_CMD   = 2000,
  parameter int T_NIB   = 50,
  parameter int T_CLR   = 82000
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  lcd_char_responder_if.slave  cpu,
  output logic                 oLCD_Enabled,
  output logic                 oLCD_RegisterSelect,
  output logic                 oLCD_ReadWrite,
  output logic                 oLCD_StrataFlashControl,
  output logic [3:0]           oLCD_Data
);

  localparam int CNT_W = 20;

  // A nibble write spans 16 counts: 1 load, 2 setup, 12 E-high, 1 hold.
  localparam logic [CNT_W-1:0] c_sendLoad = CNT_W'(15);
  localparam logic [CNT_W-1:0] c_eFirst   = CNT_W'(13);
  localparam logic [CNT_W-1:0] c_eLast    = CNT_W'(2);

  typedef enum logic [3:0] {
    PWRUP   = 4'd0,
    INIT    = 4'd1,
    CONFIG  = 4'd2,
    IDLE    = 4'd3,
    SEND_HI = 4'd4,
    GAP     = 4'd5,
    SEND_LO = 4'd6,
    WAIT    = 4'd7
  } state_t;

  state_t           r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [2:0]       r_step, w_step;
  logic             r_waiting, w_waiting;
  logic [7:0]       r_byte, w_byte;
  logic             r_isCmd, w_isCmd;
  logic             r_lcdE, r_lcdRs;
  logic [3:0]       r_lcdData;

  logic             w_done;
  logic [CNT_W-1:0] w_initWait, w_cfgWait;
  logic [3:0]       w_cfgNibble;
  logic             w_sending, w_rs;
  logic [3:0]       w_nibble;

`ifdef LCD_LINE_WRAP_EN
  logic [4:0]       r_col, w_col;
`endif

  function automatic logic [CNT_W-1:0] waitLoad(input int t);
    waitLoad = CNT_W'(t - 1);
  endfunction

  assign w_done = (r_cnt == '0);

  // Function set 0x28, entry mode 0x06, display on 0x0C, clear 0x01.
  always_comb begin
    w_cfgNibble = 4'h0;
    case (r_step)
      3'd0:    w_cfgNibble = 4'h2;
      3'd1:    w_cfgNibble = 4'h8;
      3'd3:    w_cfgNibble = 4'h6;
      3'd5:    w_cfgNibble = 4'hC;
      3'd7:    w_cfgNibble = 4'h1;
      default: w_cfgNibble = 4'h0;
    endcase
  end

  always_comb begin
    w_initWait = waitLoad(T_CMD);
    case (r_step)
      3'd0:    w_initWait = waitLoad(T_INIT1);
      3'd1:    w_initWait = waitLoad(T_INIT2);
      default: w_initWait = waitLoad(T_CMD);
    endcase
    if (r_step == 3'd7)
      w_cfgWait = waitLoad(T_CLR);
    else if (r_step[0])
      w_cfgWait = waitLoad(T_CMD);
    else
      w_cfgWait = waitLoad(T_NIB);
  end

  always_comb begin
    w_state   = r_state;
    w_cnt     = w_done ? r_cnt : r_cnt - CNT_W'(1);
    w_step    = r_step;
    w_waiting = r_waiting;
    w_byte    = r_byte;
    w_isCmd   = r_isCmd;
`ifdef LCD_LINE_WRAP_EN
    w_col     = r_col;
`endif
    case (r_state)
      PWRUP: begin
        // Counter is cleared by reset, so the power-up wait is armed here.
        if (!r_waiting) begin
          w_waiting = 1'b1;
          w_cnt     = waitLoad(T_PWRUP);
        end else if (w_done) begin
          w_state   = INIT;
          w_step    = 3'd0;
          w_waiting = 1'b0;
          w_cnt     = c_sendLoad;
        end
      end
      INIT: begin
        if (w_done) begin
          if (!r_waiting) begin
            w_waiting = 1'b1;
            w_cnt     = w_initWait;
          end else begin
            w_state   = (r_step == 3'd3) ? CONFIG : INIT;
            w_step    = (r_step == 3'd3) ? 3'd0 : r_step + 3'd1;
            w_waiting = 1'b0;
            w_cnt     = c_sendLoad;
          end
        end
      end
      CONFIG: begin
        if (w_done) begin
          if (!r_waiting) begin
            w_waiting = 1'b1;
            w_cnt     = w_cfgWait;
          end else if (r_step == 3'd7) begin
            w_state   = IDLE;
            w_waiting = 1'b0;
`ifdef LCD_LINE_WRAP_EN
            w_col     = 5'd0;
`endif
          end else begin
            w_step    = r_step + 3'd1;
            w_waiting = 1'b0;
            w_cnt     = c_sendLoad;
          end
        end
      end
      IDLE: begin
        if (cpu.iData_Ready) begin
          w_byte  = cpu.iData;
          w_isCmd = 1'b0;
          w_state = SEND_HI;
          w_cnt   = c_sendLoad;
        end
      end
      SEND_HI: if (w_done) begin w_state = GAP;     w_cnt = waitLoad(T_NIB); end
      GAP:     if (w_done) begin w_state = SEND_LO; w_cnt = c_sendLoad;      end
      SEND_LO: if (w_done) begin w_state = WAIT;    w_cnt = waitLoad(T_CMD); end
      WAIT: begin
        if (w_done) begin
          w_state = IDLE;
`ifdef LCD_LINE_WRAP_EN
          // 5-bit column wraps 31 -> 0 on its own; 16th and 32nd chars trigger a cursor move.
          if (!r_isCmd) begin
            w_col = r_col + 5'd1;
            if (r_col == 5'd15 || r_col == 5'd31) begin
              w_state = SEND_HI;
              w_cnt   = c_sendLoad;
              w_isCmd = 1'b1;
              w_byte  = (r_col == 5'd15) ? 8'hC0 : 8'h80;
            end
          end
`endif
        end
      end
      default: begin
        w_state   = PWRUP;
        w_waiting = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_sending = 1'b0;
    w_nibble  = r_byte[7:4];
    w_rs      = 1'b0;
    case (r_state)
      INIT: begin
        w_sending = !r_waiting;
        w_nibble  = (r_step == 3'd3) ? 4'h2 : 4'h3;
      end
      CONFIG: begin
        w_sending = !r_waiting;
        w_nibble  = w_cfgNibble;
      end
      SEND_HI: begin
        w_sending = 1'b1;
        w_nibble  = r_byte[7:4];
        w_rs      = !r_isCmd;
      end
      SEND_LO: begin
        w_sending = 1'b1;
        w_nibble  = r_byte[3:0];
        w_rs      = !r_isCmd;
      end
      default: w_sending = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= PWRUP;
      r_cnt     <= '0;
      r_step    <= 3'd0;
      r_waiting <= 1'b0;
      r_byte    <= 8'h00;
      r_isCmd   <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_step    <= w_step;
      r_waiting <= w_waiting;
      r_byte    <= w_byte;
      r_isCmd   <= w_isCmd;
    end
  end

`ifdef LCD_LINE_WRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_col <= 5'd0;
    else        r_col <= w_col;
  end
`endif

  // Data/RS stay parked after a write, giving the hold cycle for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lcdE    <= 1'b0;
      r_lcdRs   <= 1'b0;
      r_lcdData <= 4'h0;
    end else if (w_sending) begin
      r_lcdData <= w_nibble;
      r_lcdRs   <= w_rs;
      r_lcdE    <= (r_cnt <= c_eFirst) && (r_cnt >= c_eLast);
    end else begin
      r_lcdE    <= 1'b0;
    end
  end

  assign cpu.oReadyForData        = (r_state == IDLE);
  assign oLCD_Enabled             = r_lcdE;
  assign oLCD_RegisterSelect      = r_lcdRs;
  assign oLCD_Data                = r_lcdData;
  assign oLCD_ReadWrite           = 1'b0;
  assign oLCD_StrataFlashControl  = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_lcd_char_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_char_responder
// Brief    : Directed bench for lcd_char_responder with short simulation timings.
// Revision : 1.0
// ============================================================================
module tb_lcd_char_responder;
  localparam int T_PWRUP = 40;
  localparam int T_INIT1 = 20;
  localparam int T_INIT2 = 10;
  localparam int T_CMD   = 8;
  localparam int T_NIB   = 4;
  localparam int T_CLR   = 16;
  localparam int E_HIGH  = 12;
  localparam int BUDGET  = 3000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       lcdE, lcdRs, lcdRw, lcdSf;
  logic [3:0] lcdData;

  lcd_char_responder_if cpu ();

  lcd_char_responder #(
    .T_PWRUP(T_PWRUP), .T_INIT1(T_INIT1), .T_INIT2(T_INIT2),
    .T_CMD(T_CMD), .T_NIB(T_NIB), .T_CLR(T_CLR)
  ) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .cpu                     (cpu),
    .oLCD_Enabled            (lcdE),
    .oLCD_RegisterSelect     (lcdRs),
    .oLCD_ReadWrite          (lcdRw),
    .oLCD_StrataFlashControl (lcdSf),
    .oLCD_Data               (lcdData)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] d;
    logic       rs;
    int         rise;
    int         fall;
    bit         stable;
  } pulse_t;

  pulse_t pulses[$];
  pulse_t cur;
  int     cyc = 0;
  int     readyRise = -1;
  logic   prevE = 1'b0;
  logic   prevReady = 1'b0;
  int     checks = 0;
  int     passes = 0;
  int     fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // E-pulse recorder: captures nibble/RS at rise, stability while high, and cycle stamps.
  always @(negedge clk) begin
    if (lcdE && !prevE) begin
      cur.d      <= lcdData;
      cur.rs     <= lcdRs;
      cur.rise   <= cyc;
      cur.fall   <= -1;
      cur.stable <= 1'b1;
    end else if (lcdE && (lcdData !== cur.d || lcdRs !== cur.rs)) begin
      cur.stable <= 1'b0;
    end
    if (!lcdE && prevE)
      pulses.push_back('{cur.d, cur.rs, cur.rise, cyc, cur.stable});
    if (cpu.oReadyForData === 1'b1 && prevReady !== 1'b1)
      readyRise <= cyc;
    prevE     <= lcdE;
    prevReady <= cpu.oReadyForData;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic waitReady(input string tag);
    int n = 0;
    while (cpu.oReadyForData !== 1'b1 && n < BUDGET) begin
      tick();
      n++;
    end
    check({tag, "_ready_timeout"}, {143'd0, cpu.oReadyForData}, 144'd1);
  endtask

  task automatic strobe(input logic [7:0] b);
    cpu.iData       = b;
    cpu.iData_Ready = 1'b1;
    tick();
    cpu.iData_Ready = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, input string tag);
    waitReady(tag);
    strobe(b);
  endtask

  task automatic checkInitSeq(input string tag);
    logic [47:0] nibs = '0;
    logic [11:0] rsv = '0;
    bit allHi = 1'b1;
    bit allStable = 1'b1;
    check({tag, "_count"}, pulses.size(), 12);
    if (pulses.size() == 12) begin
      for (int i = 0; i < 12; i++) begin
        nibs = {nibs[43:0], pulses[i].d};
        rsv  = {rsv[10:0], pulses[i].rs};
        if (pulses[i].fall - pulses[i].rise != E_HIGH) allHi = 1'b0;
        if (!pulses[i].stable) allStable = 1'b0;
      end
      check({tag, "_nibbles"}, nibs, 48'h3332_2806_0C01);
      check({tag, "_rs"}, rsv, 12'h000);
      check({tag, "_e_high12"}, allHi, 1);
      check({tag, "_stable"}, allStable, 1);
      // Low time between pulses = hold(1) + wait + load/setup(3).
      check({tag, "_gap_init1"}, pulses[1].rise - pulses[0].fall, 1 + T_INIT1 + 3);
      check({tag, "_gap_init2"}, pulses[2].rise - pulses[1].fall, 1 + T_INIT2 + 3);
      check({tag, "_gap_cmd"},   pulses[3].rise - pulses[2].fall, 1 + T_CMD + 3);
      check({tag, "_gap_nib"},   pulses[5].rise - pulses[4].fall, 1 + T_NIB + 3);
      check({tag, "_ready_after_clr"}, readyRise - pulses[11].fall, T_CLR + 1);
    end
  endtask

  initial begin
    int acceptCyc;
    logic [143:0] expN, obsN;
    logic [35:0]  expRs, obsRs;
    int nExp;
    logic [7:0] ch;

    cpu.iData       = 8'h00;
    cpu.iData_Ready = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_outputs", {lcdE, lcdRs, lcdData, cpu.oReadyForData}, 7'b0);
    check("rst_rw_sf", {lcdRw, lcdSf}, 2'b01);

    // Test 1 + 3: init sequence with ignored strobes during init
    pulses.delete();
    rst_n = 1'b1;
    repeat (5) tick();
    strobe(8'h55);
    repeat (100) tick();
    strobe(8'h66);
    check("t1_not_ready_mid_init", cpu.oReadyForData, 0);
    waitReady("t1");
    checkInitSeq("t1");

    // Test 2 + 3: one-cycle strobe of 0x41, extra strobe mid-byte
    pulses.delete();
    strobe(8'h41);
    acceptCyc = cyc;
    check("t2_ready_fall", cpu.oReadyForData, 0);
    repeat (20) tick();
    strobe(8'h99);
    waitReady("t2");
    check("t2_count", pulses.size(), 2);
    if (pulses.size() == 2) begin
      check("t2_nibbles", {pulses[0].d, pulses[1].d}, 8'h41);
      check("t2_rs", {pulses[0].rs, pulses[1].rs}, 2'b11);
      check("t2_latency", pulses[0].rise - acceptCyc, 3);
      check("t2_e_high_hi", pulses[0].fall - pulses[0].rise, E_HIGH);
      check("t2_e_high_lo", pulses[1].fall - pulses[1].rise, E_HIGH);
      check("t2_nib_gap", pulses[1].rise - pulses[0].fall, 1 + T_NIB + 3);
      check("t2_ready_return", readyRise - pulses[1].fall, T_CMD + 1);
    end

    // Test 4: strobe held 30 cycles -> single write
    pulses.delete();
    cpu.iData       = 8'h42;
    cpu.iData_Ready = 1'b1;
    repeat (30) tick();
    cpu.iData_Ready = 1'b0;
    check("t4_busy_after_hold", cpu.oReadyForData, 0);
    waitReady("t4");
    check("t4_count", pulses.size(), 2);
    if (pulses.size() == 2)
      check("t4_nibbles", {pulses[0].d, pulses[1].d}, 8'h42);

    // Test 5: reset between nibbles of 0x43
    pulses.delete();
    strobe(8'h43);
    for (int i = 0; i < 100 && pulses.size() < 1; i++) tick();
    check("t5_hi_nibble_seen", pulses.size(), 1);
    repeat (2) tick();
    check("t5_held_before_rst", {lcdRs, lcdData}, 5'h14);
    rst_n = 1'b0;
    #1;
    check("t5_async_reset", {lcdE, lcdRs, lcdData, cpu.oReadyForData}, 7'b0);
    repeat (3) tick();
    pulses.delete();
    rst_n = 1'b1;
    waitReady("t5");
    checkInitSeq("t5");

    // Test 6: 17 characters 'A'..'Q'
    pulses.delete();
    for (int i = 0; i < 17; i++) begin
      ch = 8'h41 + 8'(i);
      sendByte(ch, "t6");
    end
    waitReady("t6_end");
    expN = '0; expRs = '0; nExp = 0;
    for (int i = 0; i < 17; i++) begin
`ifdef LCD_LINE_WRAP_EN
      if (i == 16) begin
        expN  = {expN[135:0], 8'hC0};
        expRs = {expRs[33:0], 2'b00};
        nExp += 2;
      end
`endif
      ch    = 8'h41 + 8'(i);
      expN  = {expN[135:0], ch};
      expRs = {expRs[33:0], 2'b11};
      nExp += 2;
    end
    obsN = '0; obsRs = '0;
    for (int i = 0; i < pulses.size() && i < 36; i++) begin
      obsN  = {obsN[139:0], pulses[i].d};
      obsRs = {obsRs[34:0], pulses[i].rs};
    end
    check("t6_count", pulses.size(), nExp);
    check("t6_nibbles", obsN, expN);
    check("t6_rs", obsRs, expRs);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
